// File: rtl/gridcell_pkg.sv
// Shared types and helpers for the grid-cell stencil register.
// Holds the FSM state enum, the neighbour index map and the clamp helper
// that the ALU uses when GRIDCELL_SAT_EN is defined.
package gridcell_pkg;

    // Update sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SUM   = 2'd1,
        APPLY = 2'd2
    } gc_state_e;

    // Neighbour slots in the packed neighbour array
    localparam int unsigned NBR_XP  = 0;  // +x (IN10)
    localparam int unsigned NBR_XN  = 1;  // -x (INNEG10)
    localparam int unsigned NBR_YP  = 2;  // +y (IN01)
    localparam int unsigned NBR_YN  = 3;  // -y (IN0NEG1)
    localparam int unsigned NUM_NBR = 4;

    // Clamp a signed value into the range of a signed word of 'width' bits
    function automatic int sat_resize(input int value, input int unsigned width);
        int hi;
        int lo;
        hi = (1 <<< (width - 1)) - 1;
        lo = -hi - 1;
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/gridcell_stencil_alu.sv
// Combinational diffusion update: lap = sum - 4*cur, delta = lap >>> ALPHA_SHIFT,
// next = cur + delta, reduced to WIDTH bits.
// Build option GRIDCELL_SAT_EN: clamp next to the signed WIDTH range;
// without it next simply wraps (two's complement truncation).
module gridcell_stencil_alu
    import gridcell_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned ALPHA_SHIFT = 2
) (
    input  logic signed [WIDTH+1:0] sum,
    input  logic signed [WIDTH-1:0] cur,
    output logic signed [WIDTH-1:0] next
);

    // WIDTH+3 bits covers sum - 4*cur and cur + delta without overflow
    logic signed [WIDTH+2:0] sum_w;
    logic signed [WIDTH+2:0] cur_w;
    logic signed [WIDTH+2:0] lap;
    logic signed [WIDTH+2:0] delta;
    logic signed [WIDTH+2:0] next_w;

    // Widen operands, form the Laplacian and the scaled step
    always_comb begin
        sum_w  = (WIDTH + 3)'(sum);
        cur_w  = (WIDTH + 3)'(cur);
        lap    = sum_w - (cur_w <<< 2);
        // Arithmetic shift floors toward minus infinity
        delta  = lap >>> ALPHA_SHIFT;
        next_w = cur_w + delta;
    end

    // Reduce the wide result back to the cell width
    always_comb begin
`ifdef GRIDCELL_SAT_EN
        next = WIDTH'(sat_resize(int'(next_w), WIDTH));
`else
        next = next_w[WIDTH-1:0];
`endif
    end

endmodule

// File: rtl/gridcell_stencil_reg.sv
// Grid-cell register with history and a pipelined diffusion update.
// A Step in IDLE registers the neighbour sum (SUM), then the ALU result is
// committed at the end of APPLY. Load overrides everything and aborts any
// update in flight. Build option GRIDCELL_SAT_EN (applied inside
// gridcell_stencil_alu) selects saturating instead of wrapping results.
module gridcell_stencil_reg
    import gridcell_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEPTH       = 2,
    parameter int unsigned ALPHA_SHIFT = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    Load,
    input  logic signed [WIDTH-1:0] VAL,
    input  logic                    Step,
    input  logic                    Pin,
    input  logic signed [WIDTH-1:0] IN10,
    input  logic signed [WIDTH-1:0] INNEG10,
    input  logic signed [WIDTH-1:0] IN01,
    input  logic signed [WIDTH-1:0] IN0NEG1,
    output logic signed [WIDTH-1:0] NEW_VAL,
    output logic signed [WIDTH-1:0] OLD_VAL,
    output logic                    Busy,
    output logic                    Valid,
    output logic [CNT_W-1:0]        StepCount
);

    gc_state_e state_q;
    gc_state_e state_d;
    logic      accept;
    logic      commit;

    logic signed [WIDTH-1:0] nbr [NUM_NBR];
    logic signed [WIDTH+1:0] sum_d;
    logic signed [WIDTH+1:0] sum_q;
    logic signed [WIDTH-1:0] cur_q;
    logic signed [WIDTH-1:0] alu_next;
    logic signed [WIDTH-1:0] commit_val;

    logic signed [WIDTH-1:0] hist_q [DEPTH];
    logic [CNT_W-1:0]        cnt_q;
    logic                    valid_q;

    assign nbr[NBR_XP] = IN10;
    assign nbr[NBR_XN] = INNEG10;
    assign nbr[NBR_YP] = IN01;
    assign nbr[NBR_YN] = IN0NEG1;

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle controls; Load wins over any Step or commit
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        commit  = 1'b0;
        if (Load) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (Step) begin
                        accept  = 1'b1;
                        state_d = SUM;
                    end
                end
                SUM: begin
                    state_d = APPLY;
                end
                APPLY: begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Sum of the four sign-extended neighbours, WIDTH+2 bits cannot overflow
    always_comb begin
        sum_d = '0;
        for (int unsigned i = 0; i < NUM_NBR; i++) begin
            sum_d = sum_d + (WIDTH + 2)'(nbr[i]);
        end
    end

    // First pipeline stage: capture neighbour sum and current value in SUM
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sum_q <= '0;
            cur_q <= '0;
        end else if (state_q == SUM) begin
            sum_q <= sum_d;
            cur_q <= hist_q[0];
        end
    end

    gridcell_stencil_alu #(
        .WIDTH       (WIDTH),
        .ALPHA_SHIFT (ALPHA_SHIFT)
    ) u_alu (
        .sum  (sum_q),
        .cur  (cur_q),
        .next (alu_next)
    );

    // A pinned cell re-commits its own value so the history still advances
    assign commit_val = Pin ? cur_q : alu_next;

    // History chain: parallel load, or shift on commit
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                hist_q[i] <= '0;
            end
        end else if (Load) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                hist_q[i] <= VAL;
            end
        end else if (commit) begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                hist_q[i] <= hist_q[i-1];
            end
            hist_q[0] <= commit_val;
        end
    end

    // Committed-update counter, wraps naturally at 2^CNT_W
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q <= '0;
        end else if (Load) begin
            cnt_q <= '0;
        end else if (commit) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // One-cycle commit pulse
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= commit;
        end
    end

    assign NEW_VAL   = hist_q[0];
    assign OLD_VAL   = hist_q[DEPTH-1];
    assign Busy      = (state_q != IDLE);
    assign Valid     = valid_q;
    assign StepCount = cnt_q;

    // accept is kept for readability of the IDLE branch
    logic unused_accept;
    assign unused_accept = accept;

endmodule

// File: tb/tb_gridcell_stencil_reg.sv
// Directed bench for gridcell_stencil_reg (WIDTH=8, DEPTH=2).
// Two instances share inputs: dut2 uses ALPHA_SHIFT=2, dut0 uses ALPHA_SHIFT=0.
// Expected overflow behaviour of dut0 follows GRIDCELL_SAT_EN.
module tb_gridcell_stencil_reg;

    logic              Clk;
    logic              Reset_n;
    logic              Load;
    logic signed [7:0] VAL;
    logic              Step;
    logic              Pin;
    logic signed [7:0] IN10;
    logic signed [7:0] INNEG10;
    logic signed [7:0] IN01;
    logic signed [7:0] IN0NEG1;

    logic signed [7:0] new2, old2, new0, old0;
    logic              busy2, valid2, busy0, valid0;
    logic [7:0]        cnt2, cnt0;

    int checks = 0;
    int errors = 0;

    gridcell_stencil_reg #(.WIDTH(8), .DEPTH(2), .ALPHA_SHIFT(2), .CNT_W(8)) dut2 (
        .Clk(Clk), .Reset_n(Reset_n), .Load(Load), .VAL(VAL), .Step(Step), .Pin(Pin),
        .IN10(IN10), .INNEG10(INNEG10), .IN01(IN01), .IN0NEG1(IN0NEG1),
        .NEW_VAL(new2), .OLD_VAL(old2), .Busy(busy2), .Valid(valid2), .StepCount(cnt2)
    );

    gridcell_stencil_reg #(.WIDTH(8), .DEPTH(2), .ALPHA_SHIFT(0), .CNT_W(8)) dut0 (
        .Clk(Clk), .Reset_n(Reset_n), .Load(Load), .VAL(VAL), .Step(Step), .Pin(Pin),
        .IN10(IN10), .INNEG10(INNEG10), .IN01(IN01), .IN0NEG1(IN0NEG1),
        .NEW_VAL(new0), .OLD_VAL(old0), .Busy(busy0), .Valid(valid0), .StepCount(cnt0)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic set_nbr(input logic signed [7:0] a, input logic signed [7:0] b,
                           input logic signed [7:0] c, input logic signed [7:0] d);
        IN10 = a; INNEG10 = b; IN01 = c; IN0NEG1 = d;
    endtask

    task automatic do_load(input logic signed [7:0] v);
        @(negedge Clk);
        Load = 1'b1; VAL = v;
        @(negedge Clk);
        Load = 1'b0;
    endtask

    // Pulse Step and return at the sample point of the commit cycle
    task automatic run_step(output logic v_seen, output logic b_seen);
        @(negedge Clk); Step = 1'b1;
        @(negedge Clk); Step = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        v_seen = valid2; b_seen = busy2;
    endtask

    task automatic test_reset();
        Reset_n = 1'b1;
        #2 Reset_n = 1'b0;
        #10;
        checks++; if (new2 !== 8'h00) begin errors++; $display("FAIL reset_new_val: got %h want 00", new2); end
        checks++; if (old2 !== 8'h00) begin errors++; $display("FAIL reset_old_val: got %h want 00", old2); end
        checks++; if (busy2 !== 1'b0 || valid2 !== 1'b0) begin errors++; $display("FAIL reset_flags: busy %b valid %b want 0 0", busy2, valid2); end
        checks++; if (cnt2 !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", cnt2); end
        @(negedge Clk); Reset_n = 1'b1;
    endtask

    task automatic test_basic();
        do_load(8'sd0);
        set_nbr(8'sd4, 8'sd4, 8'sd4, 8'sd4);
        @(negedge Clk); Step = 1'b1;
        @(negedge Clk); Step = 1'b0;
        checks++; if (busy2 !== 1'b1 || valid2 !== 1'b0) begin errors++; $display("FAIL basic_sum_cycle: busy %b valid %b want 1 0", busy2, valid2); end
        @(negedge Clk);
        checks++; if (busy2 !== 1'b1 || valid2 !== 1'b0 || new2 !== 8'h00) begin errors++; $display("FAIL basic_apply_cycle: busy %b valid %b new %h want 1 0 00", busy2, valid2, new2); end
        @(negedge Clk);
        checks++; if (valid2 !== 1'b1 || busy2 !== 1'b0) begin errors++; $display("FAIL basic_commit_flags: valid %b busy %b want 1 0", valid2, busy2); end
        checks++; if (new2 !== 8'h04 || old2 !== 8'h00) begin errors++; $display("FAIL basic_values: new %h old %h want 04 00", new2, old2); end
        checks++; if (cnt2 !== 8'd1) begin errors++; $display("FAIL basic_count: got %0d want 1", cnt2); end
        checks++; if (new0 !== 8'h10) begin errors++; $display("FAIL basic_shift0: got %h want 10", new0); end
        @(negedge Clk);
        checks++; if (valid2 !== 1'b0) begin errors++; $display("FAIL basic_valid_pulse: got %b want 0", valid2); end
    endtask

    task automatic test_floor();
        logic v, b;
        do_load(8'sd0);
        set_nbr(-8'sd1, 8'sd0, 8'sd0, 8'sd0);
        run_step(v, b);
        checks++; if (new2 !== 8'hFF) begin errors++; $display("FAIL floor_neg: got %h want ff", new2); end
        checks++; if (new0 !== 8'hFF) begin errors++; $display("FAIL floor_neg_shift0: got %h want ff", new0); end
        do_load(8'sd1);
        set_nbr(8'sd0, 8'sd0, 8'sd0, 8'sd0);
        run_step(v, b);
        checks++; if (new2 !== 8'h00) begin errors++; $display("FAIL floor_pos: got %h want 00", new2); end
        checks++; if (new0 !== 8'hFD) begin errors++; $display("FAIL floor_pos_shift0: got %h want fd", new0); end
    endtask

    task automatic test_overflow();
        logic v, b;
        logic [7:0] exp0;
`ifdef GRIDCELL_SAT_EN
        exp0 = 8'h7F;
`else
        exp0 = 8'h94;
`endif
        do_load(8'sd120);
        set_nbr(8'sd127, 8'sd127, 8'sd127, 8'sd127);
        run_step(v, b);
        checks++; if (v !== 1'b1) begin errors++; $display("FAIL ovf_valid: got %b want 1", v); end
        checks++; if (new0 !== exp0) begin errors++; $display("FAIL ovf_shift0: got %h want %h", new0, exp0); end
        checks++; if (new2 !== 8'h7F) begin errors++; $display("FAIL ovf_shift2: got %h want 7f", new2); end
    endtask

    task automatic test_pin();
        do_load(8'sd10);
        set_nbr(8'sd50, 8'sd50, 8'sd50, 8'sd50);
        @(negedge Clk); Step = 1'b1;
        @(negedge Clk); Step = 1'b0;
        @(negedge Clk); Pin = 1'b1;
        @(negedge Clk);
        checks++; if (valid2 !== 1'b1) begin errors++; $display("FAIL pin_valid: got %b want 1", valid2); end
        checks++; if (new2 !== 8'h0A || old2 !== 8'h0A) begin errors++; $display("FAIL pin_values: new %h old %h want 0a 0a", new2, old2); end
        checks++; if (cnt2 !== 8'd1) begin errors++; $display("FAIL pin_count: got %0d want 1", cnt2); end
        // Pin high only before commit must not hold the value
        Pin = 1'b0;
        @(negedge Clk); Step = 1'b1;
        @(negedge Clk); Step = 1'b0; Pin = 1'b1;
        @(negedge Clk); Pin = 1'b0;
        @(negedge Clk);
        checks++; if (new2 !== 8'h32 || old2 !== 8'h0A) begin errors++; $display("FAIL unpin_values: new %h old %h want 32 0a", new2, old2); end
        checks++; if (cnt2 !== 8'd2) begin errors++; $display("FAIL unpin_count: got %0d want 2", cnt2); end
    endtask

    task automatic test_load_abort();
        @(negedge Clk); Step = 1'b1;
        @(negedge Clk); Step = 1'b0; Load = 1'b1; VAL = 8'sd33;
        @(negedge Clk); Load = 1'b0;
        checks++; if (busy2 !== 1'b0 || valid2 !== 1'b0) begin errors++; $display("FAIL abort_flags: busy %b valid %b want 0 0", busy2, valid2); end
        checks++; if (new2 !== 8'h21 || old2 !== 8'h21) begin errors++; $display("FAIL abort_values: new %h old %h want 21 21", new2, old2); end
        checks++; if (cnt2 !== 8'd0) begin errors++; $display("FAIL abort_count: got %0d want 0", cnt2); end
        @(negedge Clk);
        checks++; if (valid2 !== 1'b0) begin errors++; $display("FAIL abort_no_valid: got %b want 0", valid2); end
        // Load and Step together: Load wins
        Load = 1'b1; Step = 1'b1; VAL = -8'sd5;
        @(negedge Clk); Load = 1'b0; Step = 1'b0;
        checks++; if (busy2 !== 1'b0 || new2 !== 8'hFB) begin errors++; $display("FAIL load_priority: busy %b new %h want 0 fb", busy2, new2); end
    endtask

    task automatic test_step_ignored();
        int nv;
        nv = 0;
        do_load(8'sd0);
        set_nbr(8'sd4, 8'sd4, 8'sd4, 8'sd4);
        @(negedge Clk); Step = 1'b1;
        @(negedge Clk); Step = 1'b0;
        #2 Step = 1'b1;
        @(negedge Clk); Step = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            if (valid2 === 1'b1) nv++;
        end
        checks++; if (nv != 1) begin errors++; $display("FAIL ignored_valids: got %0d want 1", nv); end
        checks++; if (cnt2 !== 8'd1 || new2 !== 8'h04) begin errors++; $display("FAIL ignored_state: count %0d new %h want 1 04", cnt2, new2); end
    endtask

    task automatic test_back_to_back();
        logic [5:0] pat;
        do_load(8'sd0);
        set_nbr(8'sd4, 8'sd4, 8'sd4, 8'sd4);
        @(negedge Clk); Step = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge Clk);
            pat[k] = valid2;
        end
        Step = 1'b0;
        checks++; if (pat !== 6'b100100) begin errors++; $display("FAIL b2b_pattern: got %b want 100100", pat); end
        checks++; if (cnt2 !== 8'd2) begin errors++; $display("FAIL b2b_count: got %0d want 2", cnt2); end
        checks++; if (new0 !== 8'hE0 || old0 !== 8'h10) begin errors++; $display("FAIL b2b_shift0: new %h old %h want e0 10", new0, old0); end
    endtask

    task automatic test_reset_mid();
        logic v, b;
        do_load(8'sd77);
        set_nbr(8'sd1, 8'sd2, 8'sd3, 8'sd4);
        run_step(v, b);
        @(negedge Clk); Step = 1'b1;
        @(negedge Clk); Step = 1'b0;
        @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        checks++; if (new2 !== 8'h00 || old2 !== 8'h00) begin errors++; $display("FAIL midreset_values: new %h old %h want 00 00", new2, old2); end
        checks++; if (busy2 !== 1'b0 || valid2 !== 1'b0 || cnt2 !== 8'd0) begin errors++; $display("FAIL midreset_flags: busy %b valid %b count %0d want 0 0 0", busy2, valid2, cnt2); end
        @(negedge Clk); Reset_n = 1'b1;
    endtask

    task automatic test_wrap();
        int nv;
        int cyc;
        nv = 0; cyc = 0;
        do_load(8'sd0);
        set_nbr(8'sd0, 8'sd0, 8'sd0, 8'sd0);
        @(negedge Clk); Step = 1'b1;
        while (nv < 255 && cyc < 2000) begin
            @(negedge Clk); cyc++;
            if (valid2 === 1'b1) nv++;
        end
        checks++; if (nv != 255 || cnt2 !== 8'd255) begin errors++; $display("FAIL wrap_255: commits %0d count %0d want 255 255", nv, cnt2); end
        while (nv < 256 && cyc < 2000) begin
            @(negedge Clk); cyc++;
            if (valid2 === 1'b1) nv++;
        end
        Step = 1'b0;
        checks++; if (nv != 256 || cnt2 !== 8'd0) begin errors++; $display("FAIL wrap_0: commits %0d count %0d want 256 0", nv, cnt2); end
    endtask

    initial begin
        Load = 1'b0; Step = 1'b0; Pin = 1'b0; VAL = '0;
        set_nbr(8'sd0, 8'sd0, 8'sd0, 8'sd0);
        test_reset();
        test_basic();
        test_floor();
        test_overflow();
        test_pin();
        test_load_abort();
        test_step_ignored();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
